// File: rtl/mips_div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Freezes the pipeline through `stall` until the HI/LO result is valid.
module mips_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             annul,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             accept;
  logic             last_step;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   rem_sh;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // Combinational freeze request; drops in DONE so the pipeline advances once.
  assign stall = start & ~annul & (state != DONE);

  // Operand magnitudes for signed mode; unsigned mode passes operands through.
  assign abs_a = (is_signed && opa[WIDTH-1]) ? (WIDTH'(0) - opa) : opa;
  assign abs_b = (is_signed && opb[WIDTH-1]) ? (WIDTH'(0) - opb) : opb;

  // One restoring step: shift rem:quo left, trial subtract, keep if no borrow.
  assign rem_sh    = {rem, quo[WIDTH-1]};
  assign no_borrow = rem_sh[WIDTH] | (rem_sh[WIDTH-1:0] >= divisor);
  assign rem_n     = no_borrow ? (rem_sh[WIDTH-1:0] - divisor) : rem_sh[WIDTH-1:0];
  assign quo_n     = {quo[WIDTH-2:0], no_borrow};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; annul overrides everything.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        if (start && !annul) begin
          accept  = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last_step = 1'b1;
          state_n   = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (annul) begin
      state_n   = IDLE;
      accept    = 1'b0;
      last_step = 1'b0;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      lo      <= '0;
      hi      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_n == BUSY);
      done <= (state_n == DONE);
      if (accept) begin
        divisor <= abs_b;
        quo     <= abs_a;
        rem     <= '0;
        cnt     <= '0;
        neg_q   <= is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        neg_r   <= is_signed & opa[WIDTH-1];
      end else if (state == BUSY && !annul) begin
        quo <= quo_n;
        rem <= rem_n;
        cnt <= cnt + CW'(1);
        if (last_step) begin
          lo <= neg_q ? (WIDTH'(0) - quo_n) : quo_n;
          hi <= neg_r ? (WIDTH'(0) - rem_n) : rem_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit: phase-counting reference model plus
// directed operations with hand-computed HI/LO results.
module tb_mips_div_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic         annul;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] lo;
  logic [W-1:0] hi;

  int errors = 0;
  int checks = 0;

  mips_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .annul     (annul),
    .opa       (opa),
    .opb       (opb),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .lo        (lo),
    .hi        (hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference divide from the sign rules: magnitudes, then sign correction.
  function automatic logic [2*W-1:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    logic [W-1:0] ma, mb, q, r;
    logic na, nb;
    na = s & a[W-1];
    nb = s & b[W-1];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    if (mb == 0) begin
      q = '1;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {r, q};
  endfunction

  // Model timeline: phase 0 idle, 1..W iterating, W+1 result cycle.
  int           phase;
  logic [W-1:0] m_lo, m_hi;
  logic [2*W-1:0] pend;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase = 0;
      m_lo  = '0;
      m_hi  = '0;
    end else if (annul) begin
      phase = 0;
    end else if (phase == 0) begin
      if (start) begin
        pend  = model_div(opa, opb, is_signed);
        phase = 1;
      end
    end else if (phase <= W) begin
      phase++;
      if (phase == W + 1) begin
        m_lo = pend[W-1:0];
        m_hi = pend[2*W-1:W];
      end
    end else begin
      phase = 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("stall", stall, start & ~annul & (phase != W + 1));
    chk("busy",  busy,  (phase >= 1 && phase <= W));
    chk("done",  done,  (phase == W + 1));
    chk("lo",    lo,    m_lo);
    chk("hi",    hi,    m_hi);
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] el, input logic [W-1:0] eh,
                        input bit keep, input string nm);
    int n;
    bit seen;
    @(posedge clk);
    #1;
    opa = a; opb = b; is_signed = s; start = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
      else if (n >= 2) begin
        opa = $urandom;
        opb = $urandom;
      end
    end
    chk({nm, "_done_seen"}, W'(seen), W'(1));
    if (seen) begin
      chk({nm, "_latency"}, W'(n - 1), W'(33));
      chk({nm, "_lo"}, lo, el);
      chk({nm, "_hi"}, hi, eh);
      chk({nm, "_stall_in_done"}, W'(stall), W'(0));
    end
    if (!keep) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  initial begin
    bit saw;
    rst = 1'b0; start = 1'b0; is_signed = 1'b0; annul = 1'b0; opa = '0; opb = '0;
    @(negedge clk);
    chk("reset_lo", lo, W'(0));
    chk("reset_busy", W'(busy), W'(0));
    @(posedge clk);
    #1 rst = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0, "divu_100_7");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, "div_m7_2");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 0, "div_7_m2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 0, "div_ovf");
    run_op(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 0, "divu_by0");

    // Annul mid-iteration: result registers must keep the divide-by-zero result.
    @(posedge clk);
    #1 opa = 32'd1000; opb = 32'd3; is_signed = 1'b0; start = 1'b1;
    repeat (11) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    chk("annul_stall", W'(stall), W'(0));
    @(posedge clk);
    #1 annul = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("annul_busy", W'(busy), W'(0));
    chk("annul_lo", lo, 32'hFFFF_FFFF);
    chk("annul_hi", hi, 32'h1234_5678);
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    chk("annul_no_done", W'(saw), W'(0));

    // start and annul together in idle capture nothing.
    @(posedge clk);
    #1 start = 1'b1; annul = 1'b1; opa = 32'd9; opb = 32'd2;
    @(posedge clk);
    #1 start = 1'b0; annul = 1'b0;
    @(negedge clk);
    chk("start_annul_busy", W'(busy), W'(0));

    run_op(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 0, "divu_after_annul");

    // Back-to-back with start held through the result cycle.
    run_op(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1, "b2b_first");
    run_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 0, "b2b_second");

    run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 32'd1, 32'hFFFF_FFFB, 0, "div_m5_by0");
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 0, "divu_max_1");

    // Asynchronous reset between clock edges while iterating.
    @(posedge clk);
    #1 opa = 32'd77; opb = 32'd5; is_signed = 1'b0; start = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b0; start = 1'b0;
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_stall", W'(stall), W'(0));
    chk("rst_lo", lo, W'(0));
    chk("rst_hi", hi, W'(0));
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", W'(busy), W'(0));
    chk("post_rst_lo", lo, W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_div_unit.md
Name: mips_div_unit

Overview:
- Multi-cycle 32-bit radix-2 divider for MIPS DIV/DIVU, placed in the EX stage.
- Produces the stall request that holds the pipeline registers' enable low, and produces the HI/LO result.
- Acts as the stall source for the enable/clear pipeline registers. The hazard unit ORs `stall` into the freeze of IF/ID/EX registers.
- Supports cancellation by an exception flush.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  EX holds a DIV/DIVU. Held high by the stalled pipeline until `done`.
- is_signed  in  1  1 = DIV, 0 = DIVU. Sampled with operands.
- annul  in  1  flush/exception. Cancels the operation in flight.
- opa  in  WIDTH  dividend (rs).
- opb  in  WIDTH  divisor (rt).
- stall  out  1  pipeline freeze request.
- busy  out  1  iterating.
- done  out  1  one-cycle result-valid pulse.
- lo  out  WIDTH  quotient.
- hi  out  WIDTH  remainder.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; stall=0, busy=0, done=0, lo=0, hi=0; internal counter and registers cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On start=1 and annul=0, capture |opa| and |opb| (signed mode) or raw values, plus quotient and remainder signs. Counter=0, go to BUSY.
  - Operand changes after capture are ignored.
- BUSY:
  - One restoring step per cycle: shift remainder:dividend left by 1; trial subtract divisor; if no borrow, keep the difference and set quotient bit = 1.
  - Counter increments each cycle. After WIDTH steps (counter == WIDTH-1 on the transition), go to DONE.
- DONE:
  - done=1 for exactly one cycle. lo/hi are driven with sign-corrected results and hold until the next capture.
  - Return to IDLE unconditionally. A start still high in that cycle does not retrigger; it is re-evaluated in IDLE next cycle.
- Latency:
  - start accepted at edge 0; done high during cycle WIDTH+1, i.e. 33 cycles for WIDTH=32.
- stall:
  - Combinational: stall = start & ~annul & (state != DONE).
  - stall is 1 in the IDLE acceptance cycle and throughout BUSY, and 0 in DONE, so the pipeline advances exactly once the result is valid.
- busy = (state == BUSY).
- Sign rules (is_signed=1):
  - Quotient is negative iff operand signs differ.
  - Remainder takes the sign of the dividend.
  - Negation is two's complement on WIDTH bits.
- Divide by zero:
  - No trap. Same 33-cycle latency.
  - Unsigned: lo=all ones, hi=opa.
  - Signed: the unsigned-magnitude result is sign-corrected.
- Overflow (-2^31 / -1): lo=0x80000000, hi=0, with no exception.
- annul:
  - Highest priority in every state. Next edge forces IDLE, done stays 0, and lo/hi keep their previous values.
  - start and annul in the same IDLE cycle: nothing is captured.
- Reset mid-BUSY: immediate IDLE with cleared outputs; no done pulse.

Test Plan:
- DIVU: opa=100, opb=7, start held -> stall=1 for 32 cycles, done pulse on the 33rd, lo=14, hi=2, stall=0 in the done cycle.
- DIV signed: opa=-7 (0xFFFFFFF9), opb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also opa=7, opb=-2 -> lo=-3, hi=1.
- Edge cases: opa=0x80000000, opb=0xFFFFFFFF signed -> lo=0x80000000, hi=0. DIVU opa=0x12345678, opb=0 -> lo=0xFFFFFFFF, hi=0x12345678.
- Cancellation: annul at cycle 10 of BUSY -> next cycle busy=0, stall=0, no done, lo/hi unchanged from the prior result. A fresh start then completes correctly.
- Back-to-back: start held through DONE then immediately re-asserted for a new op (opa=50, opb=5) -> exactly one done per op, second lo=10, hi=0; operand changes during BUSY do not affect the result.
- Reset: assert rst low asynchronously mid-BUSY (between clock edges) -> outputs zero immediately; after release, the idle state is verified.
